// File: rtl/alu_pkg.sv
// Shared definitions for the ALU responder: data width, opcode set and
// the responder FSM state encoding.
package alu_pkg;

    // Default operand / result width.
    localparam int N = 8;

    // Operation codes carried on the request channel.
    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SHL = 3'd5,
        OP_SHR = 3'd6,
        OP_MUL = 3'd7
    } op_e;

    // Responder control states.
    //   IDLE : waiting for a request
    //   EXEC : iterating the shift-add multiplier
    //   RESP : holding a result until the consumer takes it
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    // Tells single-cycle ops apart from the iterative multiply.
    function automatic logic is_multi_cycle(input op_e op);
        return (op == OP_MUL);
    endfunction

endpackage

// File: rtl/alu_core.sv
// Purely combinational single-cycle ALU covering every opcode except MUL.
// MUL produces zero here; the responder computes it iteratively instead.
module alu_core
    import alu_pkg::*;
#(
    parameter int N = alu_pkg::N
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  op_e          op,
    output logic [N-1:0] y,
    output logic         carry
);

    // Select the result and the flag for the requested operation.
    always_comb begin
        y     = '0;
        carry = 1'b0;
        case (op)
            OP_ADD: {carry, y} = {1'b0, a} + {1'b0, b};
            OP_SUB: begin
                y     = a - b;
                carry = (a < b);
            end
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            OP_XOR: y = a ^ b;
            OP_SHL: begin
                y     = {a[N-2:0], 1'b0};
                carry = a[N-1];
            end
            OP_SHR: begin
                y     = {1'b0, a[N-1:1]};
                carry = a[0];
            end
            default: begin
                y     = '0;
                carry = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_responder.sv
// Request/response ALU server. Single-cycle ops go straight from IDLE to
// RESP; MUL spends N cycles in EXEC running a shift-add multiplier. The
// result is held on the response channel until the consumer accepts it.
module alu_responder
    import alu_pkg::*;
#(
    parameter int N     = alu_pkg::N,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [N-1:0]     req_a,
    input  logic [N-1:0]     req_b,
    input  op_e              req_op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [N-1:0]     rsp_y,
    output logic             rsp_carry,
    output logic             rsp_zero,
    output logic [CNT_W-1:0] ops_done
);

    localparam int ITER_W = (N > 1) ? $clog2(N) : 1;

    state_e              state;
    state_e              next_state;

    logic [ITER_W-1:0]   iter;
    logic [2*N-1:0]      acc;
    logic [2*N-1:0]      mcand;
    logic [N-1:0]        mplier;
    logic [2*N-1:0]      acc_next;
    logic                last_step;

    logic [N-1:0]        core_y;
    logic                core_carry;

    logic                accept;
    logic                rsp_fire;

    // Single-cycle ops are evaluated directly from the request inputs so the
    // result can be registered on the accept edge.
    alu_core #(
        .N (N)
    ) u_core (
        .a     (req_a),
        .b     (req_b),
        .op    (req_op),
        .y     (core_y),
        .carry (core_carry)
    );

    assign accept    = (state == IDLE) && req_valid;
    assign rsp_fire  = (state == RESP) && rsp_ready;
    assign last_step = (iter == ITER_W'(N - 1));

    // One shift-add step: add the shifted multiplicand when the current
    // multiplier bit is set.
    always_comb begin
        acc_next = acc;
        if (mplier[0]) begin
            acc_next = acc + mcand;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    next_state = is_multi_cycle(req_op) ? EXEC : RESP;
                end
            end
            EXEC: begin
                if (last_step) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Multiplier operands, accumulator and iteration counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            iter   <= '0;
        end else if (accept) begin
            acc    <= '0;
            mcand  <= {{N{1'b0}}, req_a};
            mplier <= req_b;
            iter   <= '0;
        end else if (state == EXEC) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            iter   <= last_step ? '0 : iter + ITER_W'(1);
        end
    end

    // Response registers: loaded on accept for single-cycle ops, or on the
    // final multiply step; otherwise held so they stay stable under stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_y     <= '0;
            rsp_carry <= 1'b0;
            rsp_zero  <= 1'b0;
        end else if (accept && !is_multi_cycle(req_op)) begin
            rsp_y     <= core_y;
            rsp_carry <= core_carry;
            rsp_zero  <= (core_y == '0);
        end else if ((state == EXEC) && last_step) begin
            rsp_y     <= acc_next[N-1:0];
            rsp_carry <= |acc_next[2*N-1:N];
            rsp_zero  <= (acc_next[N-1:0] == '0);
        end
    end

    // Completed-response counter, bumped on each response handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ops_done <= '0;
        end else if (rsp_fire) begin
            ops_done <= ops_done + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_alu_responder.sv
// Self-checking bench for alu_responder. A second instance with a 2-bit
// counter shares all inputs so counter wrap is reached in a few ops.
module tb_alu_responder;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_a;
    logic [7:0]  req_b;
    op_e         req_op;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_y;
    logic        rsp_carry;
    logic        rsp_zero;
    logic [15:0] ops_done;

    logic        w_req_ready;
    logic        w_rsp_valid;
    logic [7:0]  w_rsp_y;
    logic        w_rsp_carry;
    logic        w_rsp_zero;
    logic [1:0]  w_ops_done;

    int checks = 0;
    int failures = 0;
    int model_count = 0;

    always #5 clk = ~clk;

    alu_responder #(.N(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_y(rsp_y), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero),
        .ops_done(ops_done)
    );

    alu_responder #(.N(8), .CNT_W(2)) dut_wrap (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(w_req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .rsp_valid(w_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_y(w_rsp_y), .rsp_carry(w_rsp_carry), .rsp_zero(w_rsp_zero),
        .ops_done(w_ops_done)
    );

    // Reference ALU from plain integer arithmetic; returns {carry, y}.
    function automatic logic [8:0] ref_alu(input int op, input int a, input int b);
        int y;
        int c;
        y = 0;
        c = 0;
        case (op)
            0: begin y = (a + b) % 256; c = ((a + b) > 255) ? 1 : 0; end
            1: begin y = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
            2: y = a & b;
            3: y = a | b;
            4: y = a ^ b;
            5: begin y = (a * 2) % 256; c = a / 128; end
            6: begin y = a / 2; c = a % 2; end
            default: begin y = (a * b) % 256; c = ((a * b) > 255) ? 1 : 0; end
        endcase
        return {c[0], y[7:0]};
    endfunction

    // Issue one request, measure latency, optionally stall the response
    // (poking a competing request meanwhile), then complete the handshake.
    task automatic run_op(input op_e op, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] exp_y, input logic exp_c,
                          input int stall, input bit poke, input string name);
        int  lat;
        int  exp_lat;
        bit  seen;
        bit  ready_bad;
        exp_lat = (op == OP_MUL) ? 8 : 0;
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        rsp_ready = (stall == 0);
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL %s_accept_ready: req_ready=%b want 1", name, req_ready);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_a  = 8'($urandom);
        req_b  = 8'($urandom);
        req_op = op_e'($urandom_range(0, 7));
        lat = 0;
        seen = 0;
        ready_bad = 0;
        while (!seen && lat <= 20) begin
            if (rsp_valid === 1'b1) begin
                seen = 1;
            end else begin
                if (req_ready !== 1'b0) ready_bad = 1;
                @(posedge clk); #1;
                lat++;
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("[TB] FAIL %s_timeout: rsp_valid never rose within %0d cycles", name, lat);
            return;
        end
        checks++;
        if (lat != exp_lat || ready_bad) begin
            failures++;
            $display("[TB] FAIL %s_latency: got %0d cycles (busy ready err=%0d) want %0d", name, lat, ready_bad, exp_lat);
        end
        checks++;
        if (rsp_y !== exp_y || rsp_carry !== exp_c || rsp_zero !== (exp_y == 8'd0)) begin
            failures++;
            $display("[TB] FAIL %s_result: got y=%0d c=%b z=%b want y=%0d c=%b z=%b",
                     name, rsp_y, rsp_carry, rsp_zero, exp_y, exp_c, (exp_y == 8'd0));
        end
        if (stall > 0) begin
            for (int i = 0; i < stall; i++) begin
                if (poke) begin
                    req_valid = 1'b1;
                    req_op    = OP_ADD;
                    req_a     = 8'($urandom);
                    req_b     = 8'($urandom);
                end
                @(posedge clk); #1;
                checks++;
                if (rsp_valid !== 1'b1 || rsp_y !== exp_y || rsp_carry !== exp_c ||
                    req_ready !== 1'b0 || ops_done !== model_count[15:0]) begin
                    failures++;
                    $display("[TB] FAIL %s_hold: got v=%b y=%0d c=%b rdy=%b cnt=%0d want v=1 y=%0d c=%b rdy=0 cnt=%0d",
                             name, rsp_valid, rsp_y, rsp_carry, req_ready, ops_done, exp_y, exp_c, model_count);
                end
            end
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        model_count++;
        checks++;
        if (ops_done !== model_count[15:0] || w_ops_done !== model_count[1:0] ||
            rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL %s_complete: got cnt=%0d wcnt=%0d v=%b rdy=%b want cnt=%0d wcnt=%0d v=0 rdy=1",
                     name, ops_done, w_ops_done, rsp_valid, req_ready, model_count % 65536, model_count % 4);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        req_a = '0;
        req_b = '0;
        req_op = OP_ADD;
        #12;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_y !== 8'd0 || rsp_carry !== 1'b0 || rsp_zero !== 1'b0 ||
            ops_done !== 16'd0 || w_ops_done !== 2'd0 || req_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_state: got v=%b y=%0d c=%b z=%b cnt=%0d rdy=%b want all 0, rdy=1",
                     rsp_valid, rsp_y, rsp_carry, rsp_zero, ops_done, req_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_count = 0;
        @(posedge clk); #1;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_release: got rdy=%b v=%b want rdy=1 v=0", req_ready, rsp_valid);
        end
    endtask

    task automatic test_basic_ops();
        logic [7:0] ys [7];
        ys = '{8'd115, 8'd31, 8'd8, 8'd107, 8'd99, 8'd146, 8'd36};
        for (int i = 0; i < 7; i++) begin
            run_op(op_e'(i), 8'd73, 8'd42, ys[i], (i == 6), 0, 0, $sformatf("basic_op%0d", i));
        end
        checks++;
        if (ops_done !== 16'd7) begin
            failures++;
            $display("[TB] FAIL basic_count: ops_done=%0d want 7", ops_done);
        end
    endtask

    task automatic test_mul();
        run_op(OP_MUL, 8'd73, 8'd42, 8'd250, 1'b1, 0, 0, "mul_73x42");
    endtask

    task automatic test_edges();
        run_op(OP_ADD, 8'd200, 8'd100, 8'd44,  1'b1, 0, 0, "add_200_100");
        run_op(OP_SUB, 8'd42,  8'd42,  8'd0,   1'b0, 0, 0, "sub_42_42");
        run_op(OP_SUB, 8'd10,  8'd20,  8'd246, 1'b1, 0, 0, "sub_10_20");
    endtask

    task automatic test_backpressure();
        run_op(OP_XOR, 8'd73, 8'd42, 8'd99, 1'b0, 5, 1, "bp_xor");
        run_op(OP_MUL, 8'd15, 8'd17, 8'd255, 1'b0, 5, 1, "bp_mul");
    endtask

    task automatic test_reset_midflight();
        req_valid = 1'b1;
        req_op = OP_MUL;
        req_a = 8'd73;
        req_b = 8'd42;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_count = 0;
        checks++;
        if (rsp_valid !== 1'b0 || ops_done !== 16'd0 || w_ops_done !== 2'd0 || req_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL midreset_async: got v=%b cnt=%0d wcnt=%0d rdy=%b want v=0 cnt=0 wcnt=0 rdy=1",
                     rsp_valid, ops_done, w_ops_done, req_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        begin
            bit stray;
            stray = 0;
            repeat (12) begin
                @(posedge clk); #1;
                if (rsp_valid !== 1'b0 || req_ready !== 1'b1) stray = 1;
            end
            checks++;
            if (stray) begin
                failures++;
                $display("[TB] FAIL midreset_dropped: stray response or busy after reset, v=%b rdy=%b want v=0 rdy=1",
                         rsp_valid, req_ready);
            end
        end
        run_op(OP_ADD, 8'd1, 8'd1, 8'd2, 1'b0, 0, 0, "post_reset_add");
    endtask

    task automatic test_wrap();
        logic [8:0] r;
        logic [7:0] a;
        logic [7:0] b;
        while (model_count % 4 != 0) begin
            a = 8'($urandom);
            b = 8'($urandom);
            r = ref_alu(0, a, b);
            run_op(OP_ADD, a, b, r[7:0], r[8], 0, 0, "wrap_add");
        end
        checks++;
        if (w_ops_done !== 2'd0 || ops_done !== model_count[15:0]) begin
            failures++;
            $display("[TB] FAIL wrap: wcnt=%0d cnt=%0d want wcnt=0 cnt=%0d", w_ops_done, ops_done, model_count);
        end
    endtask

    task automatic test_random();
        logic [8:0] r;
        logic [7:0] a;
        logic [7:0] b;
        int op;
        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 7);
            a  = 8'($urandom);
            b  = 8'($urandom);
            if (i % 10 == 0) b = 8'd0;
            r  = ref_alu(op, a, b);
            run_op(op_e'(op), a, b, r[7:0], r[8], $urandom_range(0, 3), ($urandom_range(0, 1) == 1),
                   $sformatf("rand%0d_op%0d", i, op));
        end
    endtask

    initial begin
        test_reset();
        test_basic_ops();
        test_mul();
        test_edges();
        test_backpressure();
        test_reset_midflight();
        test_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
